// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / extended-load / link result and registers the
// register-file write port, forwarding tap and retired-instruction counter.
module writeback_unit #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               hold,
  input  logic               in_reg_write,
  input  logic [4:0]         in_rd,
  input  logic [1:0]         in_wb_sel,
  input  logic [2:0]         in_funct3,
  input  logic [1:0]         in_addr_low,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_load_data,
  input  logic [XLEN-1:0]    in_pc_plus4,
  output logic               reg_write,
  output logic [4:0]         write_reg,
  output logic [XLEN-1:0]    write_data,
  output logic               fwd_valid,
  output logic [4:0]         fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [COUNT_W-1:0] retire_count
);

  logic               accept;
  logic [7:0]         byte_lane [4];
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [XLEN-1:0]    load_ext;
  logic [XLEN-1:0]    result_next;
  logic               reg_write_next;
  logic               reg_write_reg;
  logic [4:0]         write_reg_reg;
  logic [XLEN-1:0]    write_data_reg;
  logic [COUNT_W-1:0] retire_count_reg;

  assign in_ready = ~hold;
  assign accept   = in_valid & ~hold;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = in_load_data[8*gi +: 8];
    end
  endgenerate

  // Halfword alignment only looks at addr bit 1; bit 0 is ignored.
  assign byte_sel = byte_lane[in_addr_low];
  assign half_sel = in_addr_low[1] ? in_load_data[31:16] : in_load_data[15:0];

  always_comb begin
    load_ext = in_load_data;
    case (in_funct3)
      3'b000:  load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext = in_load_data;
    endcase
  end

  always_comb begin
    result_next = in_alu_result;
    case (in_wb_sel)
      2'b01:   result_next = load_ext;
      2'b10:   result_next = in_pc_plus4;
      default: result_next = in_alu_result;
    endcase
  end

  assign reg_write_next = accept & in_reg_write & (in_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_write_reg    <= 1'b0;
      write_reg_reg    <= 5'd0;
      write_data_reg   <= '0;
      retire_count_reg <= '0;
    end else begin
      reg_write_reg <= reg_write_next;
      if (accept) begin
        write_reg_reg    <= in_rd;
        write_data_reg   <= result_next;
        retire_count_reg <= retire_count_reg + COUNT_W'(1);
      end
    end
  end

  assign reg_write    = reg_write_reg;
  assign write_reg    = write_reg_reg;
  assign write_data   = write_data_reg;
  assign fwd_valid    = reg_write_reg;
  assign fwd_rd       = write_reg_reg;
  assign fwd_data     = write_data_reg;
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed cases plus randomized traffic
// checked against a behavioural model of the writeback rules.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready4;
  logic        hold;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_low;
  logic [31:0] in_alu_result;
  logic [31:0] in_load_data;
  logic [31:0] in_pc_plus4;
  logic        reg_write, reg_write4;
  logic [4:0]  write_reg, write_reg4;
  logic [31:0] write_data, write_data4;
  logic        fwd_valid, fwd_valid4;
  logic [4:0]  fwd_rd, fwd_rd4;
  logic [31:0] fwd_data, fwd_data4;
  logic [31:0] retire_count;
  logic [3:0]  retire_count4;

  int errors = 0;
  int checks = 0;

  // model state
  logic        e_wr;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  logic [31:0] e_cnt;
  int          e_cnt4;

  writeback_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_addr_low(in_addr_low), .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .in_pc_plus4(in_pc_plus4), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  writeback_unit #(.XLEN(32), .COUNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4), .hold(hold),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_addr_low(in_addr_low), .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .in_pc_plus4(in_pc_plus4), .reg_write(reg_write4), .write_reg(write_reg4),
    .write_data(write_data4), .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4),
    .retire_count(retire_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] f3,
                                             input logic [1:0] al, input logic [31:0] alu,
                                             input logic [31:0] ld, input logic [31:0] pc);
    logic [31:0] b, h, r;
    b = (ld >> (8 * al)) & 32'hFF;
    h = (ld >> (16 * (al / 2))) & 32'hFFFF;
    if (sel == 2'd2) return pc;
    if (sel != 2'd1) return alu;
    case (f3)
      3'd0:    r = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    r = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    r = b;
      3'd5:    r = h;
      default: r = ld;
    endcase
    return r;
  endfunction

  task automatic step(input logic rst, input logic v, input logic h, input logic rw,
                      input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [1:0] al, input logic [31:0] alu, input logic [31:0] ld,
                      input logic [31:0] pc);
    logic acc;
    reset = rst; in_valid = v; hold = h; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_funct3 = f3; in_addr_low = al; in_alu_result = alu; in_load_data = ld; in_pc_plus4 = pc;
    #1;
    check_val("in_ready", {31'd0, in_ready}, {31'd0, ~h});
    acc = v && !h;
    if (!rst) begin
      e_wr = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_cnt = 32'd0; e_cnt4 = 0;
    end else begin
      e_wr = acc && rw && (rd != 5'd0);
      if (acc) begin
        e_rd   = rd;
        e_data = ref_result(sel, f3, al, alu, ld, pc);
        e_cnt  = e_cnt + 32'd1;
        e_cnt4 = (e_cnt4 + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
    check_val("reg_write", {31'd0, reg_write}, {31'd0, e_wr});
    check_val("write_reg", {27'd0, write_reg}, {27'd0, e_rd});
    check_val("write_data", write_data, e_data);
    check_val("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_wr});
    check_val("fwd_rd", {27'd0, fwd_rd}, {27'd0, e_rd});
    check_val("fwd_data", fwd_data, e_data);
    check_val("retire_count", retire_count, e_cnt);
    check_val("retire_count4", {28'd0, retire_count4}, e_cnt4[31:0]);
    check_val("write_data4", write_data4, e_data);
    $display("txn rst=%0b v=%0b hold=%0b rw=%0b rd=%0d sel=%0d f3=%0d al=%0d -> we=%0b wr=%0d wd=%h cnt=%0d",
             rst, v, h, rw, rd, sel, f3, al, reg_write, write_reg, write_data, retire_count);
  endtask

  logic [2:0]  ld_f3  [6] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ld_al  [6] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_007F,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    e_wr = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_cnt = 32'd0; e_cnt4 = 0;
    reset = 1'b0; in_valid = 1'b0; hold = 1'b0; in_reg_write = 1'b0; in_rd = 5'd0;
    in_wb_sel = 2'd0; in_funct3 = 3'd0; in_addr_low = 2'd0;
    in_alu_result = 32'd0; in_load_data = 32'd0; in_pc_plus4 = 32'd0;
    @(posedge clk); #1;

    // reset with an instruction presented
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    check_val("reset_count", retire_count, 32'd0);

    // ALU op
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0);
    check_val("alu_data", write_data, 32'h0000_1234);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    check_val("alu_count", retire_count, 32'd1);

    // loads
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 2'd1, ld_f3[i], ld_al[i], 32'h1111_1111, 32'h80FF_7F01, 32'd0);
      check_val("load_const", write_data, ld_exp[i]);
    end

    // x0 and link
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h5555_0000, 32'd0, 32'd0);
    check_val("x0_nowrite", {31'd0, reg_write}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 2'd2, 3'd0, 2'd0, 32'd0, 32'd0, 32'h0000_0104);
    check_val("link_data", write_data, 32'h0000_0104);

    // hold for 3 cycles, then release
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h0000_0999, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h0000_0999, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);

    // back-to-back same rd
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h100 + i, 32'd0, 32'd0);

    // counter wrap on the 4-bit instance
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h40 + i, 32'd0, 32'd0);
    check_val("wrap_count4", {28'd0, retire_count4}, 32'd0);

    // reset on an accepting edge drops the instruction
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h6666_6666, 32'd0, 32'd0);
    check_val("midreset_nowrite", {31'd0, reg_write}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
